// File: rtl/b5restoringdiv.sv
// Sequential radix-2 restoring divider for unsigned N-bit operands.
// Produces one quotient bit per cycle; a zero divisor skips straight to DONE.
module b5restoringdiv #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic [1:0]   o_dbg_state
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_m;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic [N-1:0]  r_quot;
    logic [N-1:0]  r_rem;
    logic          r_dbz;

    // The N+1-bit partial remainder is held as N bits: after each step it is
    // below the divisor, so its top bit is always zero; w_s/w_t carry the wide form.
    logic [N:0]    w_s;
    logic [N:0]    w_t;
    logic          w_restore;
    logic [N-1:0]  w_a_next;
    logic [N-1:0]  w_q_next;

    assign w_s       = {r_a, r_q[N-1]};
    assign w_t       = w_s - {1'b0, r_m};
    assign w_restore = w_t[N];
    assign w_a_next  = w_restore ? w_s[N-1:0] : w_t[N-1:0];
    assign w_q_next  = {r_q[N-2:0], ~w_restore};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (divisor == '0) begin
                            r_quot  <= '1;
                            r_rem   <= dividend;
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_a     <= '0;
                            r_q     <= dividend;
                            r_m     <= divisor;
                            r_cnt   <= CW'(N);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_a   <= w_a_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_quot  <= w_q_next;
                        r_rem   <= w_a_next;
                        r_dbz   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_b5restoringdiv.sv
// Scoreboard bench for b5restoringdiv: drivers push expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_b5restoringdiv;
    localparam int N  = 5;
    localparam int EW = 2 * N + 1;
    localparam int BUDGET = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    // valid/ready: a request is accepted when start is high at a rising edge
    // while the divider is idle; results are valid while done is high.
    b5restoringdiv #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_unexpected: got done=1 required no pending result (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("quotient", 32'(quotient), 32'(mon_e[2*N-1:N]));
                chk("remainder", 32'(remainder), 32'(mon_e[N-1:0]));
                chk("div_by_zero", 32'(div_by_zero), 32'(mon_e[2*N]));
            end
        end
    end

    // Caller sits at the first negedge after the accepting edge (k=1).
    task automatic wait_done(output int k, output int bcnt);
        k = 1;
        bcnt = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && k < BUDGET) begin
            @(negedge clk);
            k++;
            if (busy === 1'b1) bcnt++;
        end
    endtask

    task automatic issue(input logic [N-1:0] dd, input logic [N-1:0] dv,
                         input logic [N-1:0] eq, input logic [N-1:0] er, input logic ez);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        exp_q.push_back({ez, eq, er});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input logic [N-1:0] dd, input logic [N-1:0] dv,
                       input logic [N-1:0] eq, input logic [N-1:0] er, input logic ez,
                       input int lat);
        int k, b;
        issue(dd, dv, eq, er, ez);
        wait_done(k, b);
        chk("latency", k, lat);
        if (k >= BUDGET) exp_q.delete();
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, b, gap, nd;
        rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_quotient", 32'(quotient), 0);
        chk("rst_remainder", 32'(remainder), 0);
        chk("rst_dbz", 32'(div_by_zero), 0);
        chk("rst_state", 32'(dbg_state), 0);
        rst = 1'b1;

        // 13/3: latency, busy width, single-cycle done
        issue(5'd13, 5'd3, 5'd4, 5'd1, 1'b0);
        wait_done(k, b);
        chk("latency_13_3", k, 6);
        chk("busy_cycles", b, 6);
        @(negedge clk);
        chk("done_pulse_width", 32'(done), 0);
        chk("busy_after_done", 32'(busy), 0);

        // 31/1 then 7/9 with start held high
        @(negedge clk);
        dividend = 5'd31; divisor = 5'd1; start = 1'b1;
        exp_q.push_back({1'b0, 5'd31, 5'd0});
        @(negedge clk);
        wait_done(k, b);
        chk("latency_31_1", k, 6);
        dividend = 5'd7; divisor = 5'd9;
        exp_q.push_back({1'b0, 5'd0, 5'd7});
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
            if (gap == 2) start = 1'b0;
        end while (done !== 1'b1 && gap < BUDGET);
        start = 1'b0;
        chk("b2b_gap", gap, 7);

        // divide by zero, then a normal run
        run(5'd22, 5'd0, 5'd31, 5'd22, 1'b1, 1);
        run(5'd22, 5'd5, 5'd4, 5'd2, 1'b0, 6);

        // operands and start disturbed during CALC
        issue(5'd25, 5'd4, 5'd6, 5'd1, 1'b0);
        dividend = '0; divisor = '0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 4;
        while (done !== 1'b1 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        chk("latency_25_4", k, 6);
        count_dones(8, nd);
        chk("extra_done_25_4", nd, 0);

        // reset at edge E3 of a 30/7 run
        issue(5'd30, 5'd7, 5'd4, 5'd2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_quotient", 32'(quotient), 0);
        chk("abort_remainder", 32'(remainder), 0);
        chk("abort_dbz", 32'(div_by_zero), 0);
        chk("abort_state", 32'(dbg_state), 0);
        count_dones(10, nd);
        chk("abort_no_done", nd, 0);
        run(5'd30, 5'd7, 5'd4, 5'd2, 1'b0, 6);

        // reset wins over a simultaneous start
        @(negedge clk);
        rst = 1'b0; start = 1'b1; dividend = 5'd9; divisor = 5'd2;
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        chk("rst_vs_start_busy", 32'(busy), 0);
        count_dones(10, nd);
        chk("rst_vs_start_no_done", nd, 0);

        // exhaustive sweep
        for (int a = 0; a < 32; a++) begin
            for (int d = 0; d < 32; d++) begin
                if (d == 0)
                    run(N'(a), N'(d), 5'd31, N'(a), 1'b1, 1);
                else
                    run(N'(a), N'(d), N'(a / d), N'(a % d), 1'b0, 6);
            end
        end

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
